axil_reg_slave: RTL
===================

# axil_reg_slave

AXI4-Lite slave responder exposing NUM_REGS 32-bit read/write registers to fabric logic. It answers the write/read traffic issued by the AXI VIP master in the block-design bench, for example 0x1..0x4 written to 0x0, 0x4, 0x8 and 0xC and then read back. It also drives the register contents and per-register write strobes to user logic. AW and W are captured independently, and B and R are fully registered, so any VALID/READY ordering from the master is legal.

## Interface
- DATA_WIDTH, 32: AXI data width; fixed at 32.
- ADDR_WIDTH, 4: AXI byte-address width.
- NUM_REGS, 4: implemented registers, 1..2^(ADDR_WIDTH-2).
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables.
- WVALID / WREADY  in / out  1  write-data handshake.
- BRESP  out  2  OKAY=2'b00, SLVERR=2'b10.
- BVALID / BREADY  out / in  1  write-response handshake.
- ARADDR  in  ADDR_WIDTH  read address.
- ARPROT  in  3  ignored.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID / RREADY  out / in  1  read-data handshake.
- reg_q  out  32*NUM_REGS  register contents; reg i at [32i+31:32i].
- reg_wr  out  NUM_REGS  one-cycle pulse when reg i is written.

## Operation
- Register index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- Index >= NUM_REGS: write discarded with BRESP=SLVERR; read returns RDATA=0 with RRESP=SLVERR.
- Write path uses two one-deep holding slots, aw_full and w_full.
  - AWREADY = !aw_full; WREADY = !w_full.
  - A handshake loads the slot.
- Commit fires on an edge where aw_full & w_full & (!BVALID | BREADY).
  - Updates only the bytes enabled by WSTRB; WSTRB=0 leaves the register unchanged but still returns OKAY.
  - Clears both slots.
  - Sets BVALID with BRESP.
  - Pulses reg_wr[idx] for one cycle, only on a mapped write.
- BVALID clears on BVALID&BREADY unless a new commit fires on the same edge, in which case it stays high with the new BRESP.
- Read path: ARREADY = !RVALID | RREADY.
  - An AR handshake registers RDATA/RRESP and sets RVALID.
  - RVALID clears on RVALID&RREADY with no new AR.
  - RDATA/RRESP hold stable while RVALID & !RREADY.
- Read and write are fully independent.
- A read captured on the same edge as a commit to the same register returns the pre-write value.

## Timing
- Reset (sampled at an edge with ARESET=1):
  - all reg_q = 0, reg_wr = 0;
  - aw_full = w_full = 0;
  - BVALID = RVALID = 0, BRESP = RRESP = 0, RDATA = 0.
  - AWREADY, WREADY, ARREADY are forced 0 while ARESET=1 and read 1 from the first cycle after release.
- Reset mid-transaction drops any held AW/W and any pending B/R; no commit occurs.
- Write latency: AW and W handshake at edge k, then:
  - commit and BVALID=1 at edge k+1;
  - reg_q and reg_wr change at edge k+1.
- Split AW/W: commit at the edge after the later of the two handshakes.
- Slots are free again after the commit edge, so the next AW/W may handshake while B is still pending. Sustained rate is 1 write per 2 cycles with BREADY=1.
- Back-pressure: a commit waits while BVALID & !BREADY; AWREADY/WREADY stay 0 while the slots are full.
- Read latency: AR handshake at edge k gives RVALID=1 after edge k. With RREADY=1 the rate is 1 read per cycle.

## Test plan
- Bench-equivalent sequence: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read all four.
  - Each BRESP=OKAY; reads return 0x1..0x4 with RRESP=OKAY.
  - reg_wr pulses 0001, 0010, 0100, 1000 in order.
- Ordering: W presented 3 cycles before AW to 0x4, data 0xDEADBEEF.
  - WREADY drops after the W handshake.
  - BVALID rises one edge after the AW handshake; reg 1 = 0xDEADBEEF.
- Byte strobes: reg 2 = 0x11223344, then write 0xAABBCCDD with WSTRB=0x5.
  - Reg 2 = 0x11BB33DD.
- Back-pressure:
  - BREADY=0 for 10 cycles after write A: BVALID holds; a second AW/W is accepted but does not commit (reg unchanged) until BREADY=1, then commits on that edge.
  - RREADY=0: RDATA is stable.
- Unmapped and out of reset:
  - With NUM_REGS=3, write to 0xC gives BRESP=SLVERR, no reg_wr, reg_q unchanged; read of 0xC gives RDATA=0, RRESP=SLVERR.
  - Reset asserted with BVALID=1 and aw_full=1: the next cycle has BVALID=0, AWREADY=0, and all reg_q=0.
- Same-edge read/write: reg 0 = 0x5; write 0x9 to 0x0 committing on the same edge as an AR to 0x0.
  - Read returns 0x5; a following read returns 0x9.

Source files
------------

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers to fabric logic.
// AW and W are held in independent one-deep slots; B and R are fully registered.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [DATA_WIDTH*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  aw_full_q, aw_full_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;

    logic             aw_hs, w_hs, ar_hs, commit;
    logic             w_mapped, r_mapped;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_ok;

    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Ready outputs are masked by reset so nothing handshakes while it is held.
    assign AWREADY = !aw_full_q && !ARESET;
    assign WREADY  = !w_full_q && !ARESET;
    assign ARREADY = (!rvalid_q || RREADY) && !ARESET;

    assign aw_hs    = AWVALID && AWREADY;
    assign w_hs     = WVALID && WREADY;
    assign ar_hs    = ARVALID && ARREADY;
    assign commit   = aw_full_q && w_full_q && (!bvalid_q || BREADY);
    assign ar_idx   = ARADDR[ADDR_WIDTH-1:2];
    assign w_mapped = 32'(aw_idx_q) < 32'(NUM_REGS);
    assign r_mapped = 32'(ar_idx) < 32'(NUM_REGS);

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;
    assign reg_wr = reg_wr_q;

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
        end
    end

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg_wr_d  = '0;
        regs_d    = regs_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = AWADDR[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        // A commit can only happen with both slots full, so it never races a slot load.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_mapped ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_idx_q == IDX_W'(i)) begin
                    reg_wr_d[i] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Reads sample regs_q, so a read on a commit edge sees the old contents.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = r_mapped ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_idx == IDX_W'(i)) begin
                    rdata_d = regs_q[i];
                end
            end
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            reg_wr_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            reg_wr_q  <= reg_wr_d;
            regs_q    <= regs_d;
        end
    end

endmodule
